// File: rtl/alu_pkg.sv
// Shared constants for the ALU stream unit: datapath width and opcode encodings.
package alu_pkg;
    localparam int ALU_W = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NOTA = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_NAND = 3'b111;
endpackage

// File: rtl/ALU_Project.sv
// Combinational 32-bit ALU core; no flags, ADD/SUB wrap modulo 2^32.
module ALU_Project
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] LHS,
    input  logic [ALU_W-1:0] RHS,
    input  logic [2:0]       opp,
    output logic [ALU_W-1:0] res
);
    always_comb begin
        res = '0;
        case (opp)
            OP_AND:  res = LHS & RHS;
            OP_OR:   res = LHS | RHS;
            OP_ADD:  res = LHS + RHS;
            OP_NOTA: res = ~LHS;
            OP_SUB:  res = LHS - RHS;
            OP_XOR:  res = LHS ^ RHS;
            OP_SLT:  res = {{(ALU_W-1){1'b0}}, ($signed(LHS) < $signed(RHS))};
            OP_NAND: res = ~(LHS & RHS);
            default: res = '0;
        endcase
    end
endmodule

// File: rtl/alu_stream_unit.sv
// Flow-controlled wrapper around ALU_Project: in-order command FIFO feeding a
// registered result stage, both with valid/ready handshakes.
module alu_stream_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ALU_W-1:0] in_lhs,
    input  logic [ALU_W-1:0] in_rhs,
    input  logic [2:0]       in_opp,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] out_res,
    output logic [2:0]       out_opp,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic [15:0]      op_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ALU_W-1:0] mem_lhs [DEPTH];
    logic [ALU_W-1:0] mem_rhs [DEPTH];
    logic [2:0]       mem_opp [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic             handshake;
    logic [ALU_W-1:0] head_res;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot early.
    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign pop       = (count != '0) && (!out_valid || out_ready);
    assign handshake = out_valid && out_ready;
    assign busy      = (count != '0) || out_valid;

    ALU_Project u_core (
        .LHS (mem_lhs[rd_ptr]),
        .RHS (mem_rhs[rd_ptr]),
        .opp (mem_opp[rd_ptr]),
        .res (head_res)
    );

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_lhs[wr_ptr] <= in_lhs;
            mem_rhs[wr_ptr] <= in_rhs;
            mem_opp[wr_ptr] <= in_opp;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_opp   <= '0;
            out_tag   <= '0;
            op_count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            if (pop) begin
                out_valid <= 1'b1;
                out_res   <= head_res;
                out_opp   <= mem_opp[rd_ptr];
                out_tag   <= mem_tag[rd_ptr];
            end else if (handshake) begin
                out_valid <= 1'b0;
            end

            if (handshake) begin
                op_count <= op_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_alu_stream_unit.sv
// Randomized and directed checks of alu_stream_unit against a queue-based reference model.
module tb_alu_stream_unit;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_lhs;
    logic [31:0] in_rhs;
    logic [2:0]  in_opp;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [2:0]  out_opp;
    logic [3:0]  out_tag;
    logic        busy;
    logic [15:0] op_count;

    alu_stream_unit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_lhs    (in_lhs),
        .in_rhs    (in_rhs),
        .in_opp    (in_opp),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_opp   (out_opp),
        .out_tag   (out_tag),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
    } cmd_t;

    cmd_t        fifo_q[$];
    logic        m_valid;
    logic [31:0] m_res;
    logic [2:0]  m_op;
    logic [3:0]  m_tag;
    logic [15:0] m_cnt;
    int          hs_total;
    logic        last_acc;
    logic        last_hs;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return ~a;
            3'd4:    return a - b;
            3'd5:    return a ^ b;
            3'd6:    return (sa < sb) ? 32'd1 : 32'd0;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic model_clear();
        fifo_q.delete();
        m_valid  = 1'b0;
        m_res    = '0;
        m_op     = '0;
        m_tag    = '0;
        m_cnt    = '0;
        hs_total = 0;
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tg, input logic ordy, input logic r);
        logic m_push;
        logic m_pop;
        logic m_hs;
        cmd_t c;
        in_valid  = v;
        in_opp    = op;
        in_lhs    = a;
        in_rhs    = b;
        in_tag    = tg;
        out_ready = ordy;
        rst       = r;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (fifo_q.size() < DEPTH)});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("busy", {31'd0, busy}, {31'd0, (fifo_q.size() != 0) || m_valid});
        chk("op_count", {16'd0, op_count}, {16'd0, m_cnt});
        if (m_valid) begin
            chk("out_res", out_res, m_res);
            chk("out_opp", {29'd0, out_opp}, {29'd0, m_op});
            chk("out_tag", {28'd0, out_tag}, {28'd0, m_tag});
        end
        m_push   = v && (fifo_q.size() < DEPTH);
        m_pop    = (fifo_q.size() != 0) && (!m_valid || ordy);
        m_hs     = m_valid && ordy;
        last_acc = m_push && !r;
        last_hs  = m_hs && !r;
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            if (m_hs) begin
                m_cnt++;
                hs_total++;
            end
            if (m_pop) begin
                c       = fifo_q.pop_front();
                m_res   = alu_ref(c.op, c.a, c.b);
                m_op    = c.op;
                m_tag   = c.tag;
                m_valid = 1'b1;
            end else if (m_hs) begin
                m_valid = 1'b0;
            end
            if (m_push) begin
                c.op  = op;
                c.a   = a;
                c.b   = b;
                c.tag = tg;
                fifo_q.push_back(c);
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 3'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic single_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        step(1'b1, op, a, b, 4'd5, 1'b1, 1'b0);
        chk({tag, "_lat_n"}, {31'd0, out_valid}, 32'd0);
        idle(1'b1);
        chk({tag, "_lat_n1"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, out_res, exp);
        idle(1'b1);
    endtask

    initial begin
        int acc;
        int drained;
        int run;
        int best_run;
        logic [31:0] held;

        rst = 1'b1;
        in_valid = 1'b0; in_lhs = '0; in_rhs = '0; in_opp = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_opp", {29'd0, out_opp}, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);

        single_op("and",  3'd0, 32'hAAAAFFFF, 32'h0F0F0F0F, 32'h0A0A0F0F);
        single_op("add",  3'd2, 32'd25, 32'd75, 32'd100);
        single_op("sub",  3'd4, 32'd25, 32'd75, 32'hFFFFFFCE);
        single_op("not",  3'd3, 32'hFFFFF000, 32'h12345678, 32'h00000FFF);
        single_op("nand", 3'd7, 32'hFFFF0000, 32'hFFFF0000, 32'h0000FFFF);

        step(1'b1, 3'd6, -32'sd10, 32'd5, 4'd3, 1'b1, 1'b0);
        step(1'b1, 3'd6, 32'd100, -32'sd5, 4'd7, 1'b1, 1'b0);
        chk("slt0_res", out_res, 32'd1);
        chk("slt0_tag", {28'd0, out_tag}, 32'd3);
        idle(1'b1);
        chk("slt1_res", out_res, 32'd0);
        chk("slt1_tag", {28'd0, out_tag}, 32'd7);
        idle(1'b1);

        acc = 0;
        held = '0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'd2, $urandom, $urandom, 4'(i), 1'b0, 1'b0);
            if (last_acc) acc++;
            if (i == 1) held = out_res;
        end
        chk("bp_accepted", acc, 32'd5);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        idle(1'b0);
        idle(1'b0);
        chk("bp_stable", out_res, held);
        drained = 0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            if (last_hs) drained++;
        end
        chk("bp_drained", drained, 32'd5);
        chk("bp_busy_end", {31'd0, busy}, 32'd0);

        do_reset();
        run = 0;
        best_run = 0;
        for (int i = 0; i < 30; i++) begin
            if (i < 20) step(1'b1, 3'd5, $urandom, $urandom, 4'($urandom), 1'b1, 1'b0);
            else idle(1'b1);
            if (last_hs) run++;
            else run = 0;
            if (run > best_run) best_run = run;
        end
        chk("stream_run", best_run, 32'd20);
        chk("stream_count", {16'd0, op_count}, 32'd20);
        chk("stream_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 4; i++) step(1'b1, 3'($urandom), $urandom, $urandom, 4'(i), 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'h1, 32'h2, 4'hF, 1'b1, 1'b1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        drained = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (out_valid) drained++;
        end
        chk("mid_rst_no_output", drained, 32'd0);

        for (int i = 0; i < 4; i++) step(1'b1, 3'($urandom), $urandom, $urandom, 4'(i), 1'b0, 1'b0);
        step(1'b1, 3'd2, 32'd7, 32'd8, 4'd9, 1'b1, 1'b0);
        step(1'b1, 3'd4, 32'd9, 32'd1, 4'd10, 1'b0, 1'b0);
        chk("pp_full", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) idle(1'b1);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom, 4'($urandom),
                 ($urandom_range(0, 9) < 7), 1'b0);
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        do_reset();
        for (int i = 0; i < 65600 && hs_total < 65536; i++) begin
            step(1'b1, 3'($urandom), $urandom, $urandom, 4'($urandom), 1'b1, 1'b0);
        end
        chk("wrap_hs_total", hs_total, 32'd65536);
        chk("wrap_op_count", {16'd0, op_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
